stream_mux_rr: RTL and testbench

- Parametrised, registered successor to the team's 3-input 4-bit select mux.
- Multiplexes NUM_CH streaming channels of WIDTH bits onto one output, with valid/ready handshakes on every port.
- Two modes: fixed select (software-style sel, like the original mux) or fair round-robin arbitration.
- One-entry output register gives 1-cycle latency and full throughput. Sits between channel producers and a single downstream consumer.

---
 rtl/stream_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_mux_rr.sv | 96 +++++++++
 tb/tb_stream_mux_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int unsigned DEFAULT_WIDTH  = 4;
    localparam int unsigned DEFAULT_NUM_CH = 3;

    // Successor of a channel index, wrapping n-1 back to 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic              grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = ptr;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            if (enable && !grant && req[idx]) begin
                grant     = 1'b1;
                grant_idx = idx;
            end
            idx = SEL_W'(next_idx(32'(idx), NUM_CH));
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered NUM_CH-to-1 stream mux with fixed-select or round-robin arbitration.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_ch_q;
    logic [SEL_W-1:0] ptr_q;

    logic             load_en;
    logic             rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             fix_grant;
    logic             grant;
    logic [SEL_W-1:0] cand;
    logic [WIDTH-1:0] cand_data;
    logic             transfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .enable    (mode == MODE_RR),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Compare against each legal index so an out-of-range sel never indexes in_valid.
    always_comb begin
        fix_grant = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(sel) == i && in_valid[i]) begin
                fix_grant = 1'b1;
            end
        end
    end

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        cand     = (mode == MODE_RR) ? rr_idx : sel;
        grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
        transfer = !rst && load_en && grant;
    end

    always_comb begin
        in_ready  = '0;
        cand_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(cand) == i) begin
                in_ready[i] = transfer;
                cand_data   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cand_data;
            out_ch_q    <= cand;
            if (mode == MODE_RR) begin
                ptr_q <= SEL_W'(next_idx(32'(cand), NUM_CH));
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: default 3x4 instance plus a 5x8 instance.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic        mode;
    logic [1:0]  sel;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;

    logic        w_mode;
    logic [2:0]  w_sel;
    logic [4:0]  w_in_valid;
    logic [4:0]  w_in_ready;
    logic [39:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [7:0]  w_out_data;
    logic [2:0]  w_out_ch;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stream_mux_rr dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    stream_mux_rr #(
        .WIDTH  (8),
        .NUM_CH (5)
    ) dut_w (
        .clk       (clk),
        .rst       (rst),
        .mode      (w_mode),
        .sel       (w_sel),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_data  (w_out_data),
        .out_ch    (w_out_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] dat [3];
        dat[0] = 4'b1010;
        dat[1] = 4'b1111;
        dat[2] = 4'b0110;

        rst         = 1'b1;
        mode        = 1'b0;
        sel         = 2'd0;
        in_valid    = 3'b111;
        in_data     = {dat[2], dat[1], dat[0]};
        out_ready   = 1'b1;
        w_mode      = 1'b0;
        w_sel       = 3'd0;
        w_in_valid  = 5'b0;
        w_in_data   = {8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};
        w_out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ch", 32'(out_ch), 32'h0);
        rst = 1'b0;

        // Fixed select, sel 0..2 then out-of-range 3
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("fix_in_ready", 32'(in_ready), 32'(1 << s));
            tick();
            check("fix_out_valid", 32'(out_valid), 32'h1);
            check("fix_out_data", 32'(out_data), 32'(dat[s]));
            check("fix_out_ch", 32'(out_ch), 32'(s));
        end
        sel = 2'd3;
        #1;
        check("fix_sel3_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("fix_sel3_out_valid", 32'(out_valid), 32'h0);
        check("fix_sel3_hold_data", 32'(out_data), 32'(dat[2]));

        // Round-robin, all valid: 0,1,2,0,1,2 one per cycle
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_in_ready", 32'(in_ready), 32'(1 << (i % 3)));
            tick();
            check("rr_out_valid", 32'(out_valid), 32'h1);
            check("rr_out_ch", 32'(out_ch), 32'(i % 3));
            check("rr_out_data", 32'(out_data), 32'(dat[i % 3]));
        end

        // Backpressure with 1111 held
        mode = 1'b0;
        sel  = 2'd1;
        tick();
        check("bp_load", 32'(out_data), 32'(dat[1]));
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_data", 32'(out_data), 32'(dat[1]));
            check("bp_out_ch", 32'(out_ch), 32'h1);
        end
        out_ready = 1'b1;
        sel       = 2'd0;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'h1);
        check("bp_release_data", 32'(out_data), 32'(dat[0]));

        // One RR grant moves ptr to 1, then reset mid-stream must clear it
        mode = 1'b1;
        tick();
        check("pre_rst_ch", 32'(out_ch), 32'h0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_data", 32'(out_data), 32'h0);
        check("midrst_out_ch", 32'(out_ch), 32'h0);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("postrst_out_ch", 32'(out_ch), 32'h0);

        // Only ch1/ch2 valid with ptr=2: expect 2,1,2,1
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 3'b010;
        tick();
        check("ptr2_setup_ch", 32'(out_ch), 32'h1);
        in_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr12_in_ready", 32'(in_ready), (i % 2 == 0) ? 32'h4 : 32'h2);
            tick();
            check("rr12_out_ch", 32'(out_ch), (i % 2 == 0) ? 32'h2 : 32'h1);
            check("rr12_out_data", 32'(out_data), (i % 2 == 0) ? 32'h6 : 32'hF);
        end

        // Wide instance: WIDTH=8, NUM_CH=5
        w_sel      = 3'd4;
        w_in_valid = 5'b11111;
        #1;
        check("w_in_ready", 32'(w_in_ready), 32'h10);
        tick();
        check("w_out_valid", 32'(w_out_valid), 32'h1);
        check("w_out_data", 32'(w_out_data), 32'hA5);
        check("w_out_ch", 32'(w_out_ch), 32'h4);
        for (int s = 5; s < 8; s++) begin
            w_sel = 3'(s);
            #1;
            check("w_oor_in_ready", 32'(w_in_ready), 32'h0);
            tick();
            check("w_oor_out_valid", 32'(w_out_valid), 32'h0);
            check("w_oor_hold_data", 32'(w_out_data), 32'hA5);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
